dequantization_stream: RTL and testbench

DEQUANTIZATION_STREAM -- requirements
Module: dequantization_stream

---
 rtl/dequantization_stream.sv | 186 ++++++++++++++++++
 tb/tb_dequantization_stream.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dequantization_stream.sv
// Streaming dequantizer: sign-extends each quantized input and shifts it left by (cfg_shift+1).
// Optional macro DEQUANT_SAT_EN: clamp on overflow with a sticky sat_flag; otherwise results wrap.
`ifndef BITWIDTH
`define BITWIDTH 8
`endif
`ifndef BW_FL
`define BW_FL 5
`endif

module dequantization_stream #(
    parameter int GROUP_CHANNEL = 16,
    parameter int BW_OUT        = 2*`BITWIDTH+4+$clog2(GROUP_CHANNEL)+10,
    parameter int BW_LEN        = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [`BW_FL-1:0]           cfg_shift,
    input  logic [BW_LEN-1:0]           cfg_len,
    output logic                        busy,
    output logic                        done,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [`BITWIDTH-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [BW_OUT-1:0]    out_data,
    output logic                        out_last,
    output logic                        sat_flag
);
    localparam int SHW = `BW_FL + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                      r_state;
    state_t                      w_nextState;
    logic [`BW_FL-1:0]           r_shift;
    logic [BW_LEN-1:0]           r_len;
    logic [BW_LEN-1:0]           r_inCnt;
    logic [BW_LEN-1:0]           r_outCnt;
    logic                        r_s1Valid;
    logic signed [`BITWIDTH-1:0] r_s1Data;
    logic                        r_s2Valid;
    logic signed [BW_OUT-1:0]    r_s2Data;
    logic                        r_done;

    logic                        w_startOk;
    logic                        w_startZero;
    logic                        w_inFire;
    logic                        w_outFire;
    logic                        w_s2Adv;
    logic                        w_inLast;
    logic                        w_outLast;
    logic [SHW-1:0]              w_shamt;
    logic signed [BW_OUT-1:0]    w_result;

    assign w_startOk   = (r_state == IDLE) && start && (cfg_len != '0);
    assign w_startZero = (r_state == IDLE) && start && (cfg_len == '0);
    assign w_s2Adv     = !r_s2Valid || out_ready;
    assign in_ready    = (r_state == RUN) && (!r_s1Valid || !r_s2Valid || out_ready);
    assign w_inFire    = in_valid && in_ready;
    assign w_outFire   = r_s2Valid && out_ready;
    assign w_inLast    = (r_inCnt == r_len - BW_LEN'(1));
    assign w_outLast   = r_s2Valid && (r_outCnt == r_len - BW_LEN'(1));
    assign w_shamt     = {1'b0, r_shift} + SHW'(1);

`ifdef DEQUANT_SAT_EN
    // Compute at full precision so any shift amount can be range-checked before clamping.
    localparam int MAX_SH = (1 << `BW_FL);
    localparam int W_WIDE = BW_OUT + MAX_SH + 1;

    logic signed [W_WIDE-1:0]    w_wide;
    logic [W_WIDE-BW_OUT:0]      w_wideTop;
    logic                        w_ovf;
    logic                        r_sat;

    assign w_wide    = {{(W_WIDE-`BITWIDTH){r_s1Data[`BITWIDTH-1]}}, r_s1Data} <<< w_shamt;
    assign w_wideTop = w_wide[W_WIDE-1:BW_OUT-1];
    assign w_ovf     = !((&w_wideTop) || !(|w_wideTop));

    always_comb begin
        w_result = w_wide[BW_OUT-1:0];
        if (w_ovf) begin
            if (w_wide[W_WIDE-1]) begin
                w_result = {1'b1, {(BW_OUT-1){1'b0}}};
            end else begin
                w_result = {1'b0, {(BW_OUT-1){1'b1}}};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat <= 1'b0;
        end else if (w_startOk) begin
            r_sat <= 1'b0;
        end else if (w_s2Adv && r_s1Valid && w_ovf) begin
            r_sat <= 1'b1;
        end
    end

    assign sat_flag = r_sat;
`else
    assign w_result = {{(BW_OUT-`BITWIDTH){r_s1Data[`BITWIDTH-1]}}, r_s1Data} <<< w_shamt;
    assign sat_flag = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE:    if (w_startOk) w_nextState = RUN;
            RUN:     if (w_inFire && w_inLast) w_nextState = DRAIN;
            DRAIN:   if (w_outFire && w_outLast) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift  <= '0;
            r_len    <= '0;
            r_inCnt  <= '0;
            r_outCnt <= '0;
        end else if (w_startOk) begin
            r_shift  <= cfg_shift;
            r_len    <= cfg_len;
            r_inCnt  <= '0;
            r_outCnt <= '0;
        end else begin
            if (w_inFire) begin
                r_inCnt <= r_inCnt + BW_LEN'(1);
            end
            if (w_outFire) begin
                r_outCnt <= r_outCnt + BW_LEN'(1);
            end
        end
    end

    // s1 empties whenever its item moves on to s2 and nothing new arrives behind it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1Valid <= 1'b0;
            r_s1Data  <= '0;
        end else if (w_inFire) begin
            r_s1Valid <= 1'b1;
            r_s1Data  <= in_data;
        end else if (w_s2Adv) begin
            r_s1Valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2Valid <= 1'b0;
            r_s2Data  <= '0;
        end else if (w_s2Adv) begin
            r_s2Valid <= r_s1Valid;
            if (r_s1Valid) begin
                r_s2Data <= w_result;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_startZero || (w_outFire && w_outLast);
        end
    end

    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign out_valid = r_s2Valid;
    assign out_data  = r_s2Data;
    assign out_last  = w_outLast;

endmodule

// File: tb/tb_dequantization_stream.sv
// Scoreboard bench for dequantization_stream: expected values are queued on each input
// handshake and compared on each output handshake; honours DEQUANT_SAT_EN like the design.
`ifndef BITWIDTH
`define BITWIDTH 8
`endif
`ifndef BW_FL
`define BW_FL 5
`endif

module tb_dequantization_stream;
    localparam int BW_OUT = 34;
    localparam int BW_LEN = 16;

    typedef struct packed {
        logic [BW_OUT-1:0] d;
        logic              last;
    } sbEntry_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [`BW_FL-1:0]    cfgShift;
    logic [BW_LEN-1:0]    cfgLen;
    logic                 busy;
    logic                 done;
    logic                 inValid;
    logic                 inReady;
    logic [`BITWIDTH-1:0] inData;
    logic                 outValid;
    logic                 outReady;
    logic [BW_OUT-1:0]    outData;
    logic                 outLast;
    logic                 satFlag;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int orMode = 0;
    int tileId = 0;
    int tbShift = 0;
    int tbLen = 0;
    logic [`BITWIDTH-1:0] stim [16];

    // Monitor-owned state
    sbEntry_t sbQ [$];
    int seenTile = 0;
    int acc = 0;
    int nOut = 0;
    int inflight = 0;
    int firstAcc = 0;
    int firstOut = 0;
    int doneCnt = 0;
    logic seenOut = 1'b0;
    logic tileSat = 1'b0;
    logic expDone = 1'b0;
    logic prevStall = 1'b0;
    logic [BW_OUT-1:0] prevData = '0;
    logic prevLast = 1'b0;

    dequantization_stream #(
        .GROUP_CHANNEL(16),
        .BW_OUT       (BW_OUT),
        .BW_LEN       (BW_LEN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cfg_shift(cfgShift),
        .cfg_len  (cfgLen),
        .busy     (busy),
        .done     (done),
        .in_valid (inValid),
        .in_ready (inReady),
        .in_data  (inData),
        .out_valid(outValid),
        .out_ready(outReady),
        .out_data (outData),
        .out_last (outLast),
        .sat_flag (satFlag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // out_ready is either held high or toggled every cycle to exercise backpressure.
    always @(posedge clk) begin
        #1;
        if (orMode == 1) outReady = ~outReady;
        else outReady = 1'b1;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic modelOvf(input logic [`BITWIDTH-1:0] q, input int sh);
        longint v;
        longint maxV;
        v = longint'($signed(q)) <<< (sh + 1);
        maxV = (longint'(1) <<< (BW_OUT - 1)) - 1;
        return (v > maxV) || (v < -maxV - 1);
    endfunction

    function automatic logic [BW_OUT-1:0] modelDequant(input logic [`BITWIDTH-1:0] q, input int sh);
        longint v;
        logic [63:0] bits;
        v = longint'($signed(q)) <<< (sh + 1);
`ifdef DEQUANT_SAT_EN
        if (modelOvf(q, sh)) begin
            if (v < 0) v = -(longint'(1) <<< (BW_OUT - 1));
            else v = (longint'(1) <<< (BW_OUT - 1)) - 1;
        end
`endif
        bits = v;
        return bits[BW_OUT-1:0];
    endfunction

    always @(negedge clk) begin
        sbEntry_t e;
        if (rst) begin
            sbQ.delete();
            expDone = 1'b0;
            inflight = 0;
            prevStall = 1'b0;
        end else begin
            if (tileId != seenTile) begin
                seenTile = tileId;
                acc = 0;
                nOut = 0;
                seenOut = 1'b0;
                tileSat = 1'b0;
            end
            checkOutput("done", done, expDone);
            if (done) doneCnt++;
            if (!busy) checkOutput("in_ready_idle", inReady, 0);
            if (prevStall) begin
                checkOutput("stall_valid", outValid, 1);
                checkOutput("stall_data", outData, prevData);
                checkOutput("stall_last", outLast, prevLast);
            end
            if (inflight == 2 && !outReady) checkOutput("in_ready_full", inReady, 0);
            if (outValid && !seenOut) begin
                seenOut = 1'b1;
                firstOut = cyc;
            end
            expDone = 1'b0;
            if (inValid && inReady) begin
                e.d = modelDequant(inData, tbShift);
                e.last = (acc == tbLen - 1);
`ifdef DEQUANT_SAT_EN
                if (modelOvf(inData, tbShift)) tileSat = 1'b1;
`endif
                sbQ.push_back(e);
                if (acc == 0) firstAcc = cyc;
                acc++;
                inflight++;
            end
            if (outValid && outReady) begin
                checkOutput("sb_nonempty", sbQ.size() > 0, 1);
                if (sbQ.size() > 0) begin
                    e = sbQ.pop_front();
                    checkOutput("out_data", outData, e.d);
                    checkOutput("out_last", outLast, e.last);
                    if (e.last) expDone = 1'b1;
                end
                nOut++;
                inflight--;
            end
            if (start && !busy && cfgLen == 0) expDone = 1'b1;
            prevStall = outValid && !outReady;
            prevData = outData;
            prevLast = outLast;
        end
    end

    task automatic startTile(input int sh, input int len);
        tileId++;
        start = 1'b1;
        cfgShift = `BW_FL'(sh);
        cfgLen = BW_LEN'(len);
        tbShift = sh;
        tbLen = len;
        @(posedge clk); #1;
        start = 1'b0;
        cfgShift = ~`BW_FL'(sh);
        cfgLen = 5;
    endtask

    task automatic applyStimulus(input int first, input int n);
        logic hs;
        int tmo;
        for (int i = 0; i < n; i++) begin
            inValid = 1'b1;
            inData = stim[first + i];
            tmo = 0;
            do begin
                @(negedge clk);
                hs = inReady;
                @(posedge clk); #1;
                tmo++;
            end while (!hs && tmo < 200);
            if (!hs) checkOutput("in_timeout", hs, 1);
        end
        inValid = 1'b0;
    endtask

    task automatic waitIdle();
        int t;
        t = 0;
        @(negedge clk);
        while (busy && t < 300) begin
            @(negedge clk);
            t++;
        end
        checkOutput("idle_timeout", busy, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic checkResetValues();
        @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_in_ready", inReady, 0);
        checkOutput("rst_out_valid", outValid, 0);
        checkOutput("rst_out_last", outLast, 0);
        checkOutput("rst_out_data", outData, 0);
        checkOutput("rst_sat_flag", satFlag, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int d0;
        rst = 1'b1; start = 1'b0; cfgShift = '0; cfgLen = '0;
        inValid = 1'b0; inData = '0; outReady = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checkResetValues();
        @(posedge clk); #1;

        // Basic tile with known values 16, 2032, -2048, -16
        stim[0] = 8'h01; stim[1] = 8'h7F; stim[2] = 8'h80; stim[3] = 8'hFF;
        d0 = doneCnt;
        startTile(3, 4);
        applyStimulus(0, 4);
        waitIdle();
        checkOutput("basic_count", nOut, 4);
        checkOutput("basic_latency", firstOut - firstAcc, 2);
        checkOutput("basic_done_cnt", doneCnt - d0, 1);
        checkOutput("basic_sat", satFlag, 0);
        checkOutput("basic_sb_empty", sbQ.size(), 0);

        // Backpressure tile with an ignored start in the middle
        orMode = 1;
        for (int i = 0; i < 8; i++) stim[i] = `BITWIDTH'($urandom);
        startTile(2, 8);
        applyStimulus(0, 4);
        start = 1'b1; cfgLen = 3; cfgShift = 7;
        @(posedge clk); #1;
        start = 1'b0;
        applyStimulus(4, 4);
        waitIdle();
        orMode = 0;
        checkOutput("bp_count", nOut, 8);
        checkOutput("bp_sb_empty", sbQ.size(), 0);

        // Overflowing shift: clamps or wraps depending on build
        stim[0] = 8'h7F; stim[1] = 8'h80;
        startTile(31, 2);
        applyStimulus(0, 2);
        waitIdle();
        checkOutput("sat_count", nOut, 2);
        checkOutput("sat_flag", satFlag, tileSat);

        // Zero-length tile: done pulse only
        d0 = doneCnt;
        startTile(0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("zero_busy", busy, 0);
        end
        checkOutput("zero_done_cnt", doneCnt - d0, 1);
        @(posedge clk); #1;

        // Single-element tile
        stim[0] = 8'h9C;
        startTile(5, 1);
        applyStimulus(0, 1);
        waitIdle();
        checkOutput("len1_count", nOut, 1);

        // Reset after three of eight accepts
        for (int i = 0; i < 8; i++) stim[i] = `BITWIDTH'($urandom);
        d0 = doneCnt;
        startTile(1, 8);
        applyStimulus(0, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkResetValues();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_no_done", doneCnt - d0, 0);

        // Full tile after the mid-tile reset
        for (int i = 0; i < 8; i++) stim[i] = `BITWIDTH'($urandom);
        startTile(4, 8);
        applyStimulus(0, 8);
        waitIdle();
        checkOutput("post_rst_count", nOut, 8);
        checkOutput("post_rst_sb_empty", sbQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
